// File: rtl/uart_rx.sv
// 8N1 UART receiver: synchronized, oversampled RX line with start/stop
// validation, 1-entry valid/ready output, framing-error and overrun pulses.
//
// Ports:
//   clk, nrst         clock and synchronous active-low reset
//   bit_period        clk cycles per bit, latched at start-bit detect
//   serial_in         async RX line, idle high
//   data, valid       received byte and its valid flag
//   ready             consumer accepts data when valid && ready
//   frame_err         1-cycle pulse: stop bit sampled low
//   overrun           1-cycle pulse: byte dropped, output full
//   busy              receiver not idle
module uart_rx #(
  parameter int CNT_W   = 16,
  parameter int SYNC_FF = 2
) (
  input  logic             clk,
  input  logic             nrst,
  input  logic [CNT_W-1:0] bit_period,
  input  logic             serial_in,
  output logic [7:0]       data,
  output logic             valid,
  input  logic             ready,
  output logic             frame_err,
  output logic             overrun,
  output logic             busy
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_BREAK
  } state_t;

  state_t             r_state;
  logic [SYNC_FF-1:0] r_sync;
  logic [CNT_W-1:0]   r_bp;
  logic [CNT_W-1:0]   r_cnt;
  logic [2:0]         r_bit;
  logic [7:0]         r_shift;
  logic               r_dlv;
  logic               r_fe;
  logic               r_ov;
  logic [7:0]         r_data;
  logic               r_valid;

  logic               w_rx;
  logic [CNT_W-1:0]   w_half;
  logic [CNT_W-1:0]   w_full;

  assign w_rx   = r_sync[SYNC_FF-1];
  assign w_half = (r_bp >> 1) - CNT_W'(1);
  assign w_full = r_bp - CNT_W'(1);

  // Preset to idle-high so reset never looks like a start bit.
  always_ff @(posedge clk) begin
    if (!nrst) begin
      r_sync <= '1;
    end else begin
      r_sync <= {r_sync[SYNC_FF-2:0], serial_in};
    end
  end

  always_ff @(posedge clk) begin
    if (!nrst) begin
      r_state <= S_IDLE;
      r_bp    <= '0;
      r_cnt   <= '0;
      r_bit   <= '0;
      r_shift <= '0;
      r_dlv   <= 1'b0;
      r_fe    <= 1'b0;
    end else begin
      r_dlv <= 1'b0;
      r_fe  <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (!w_rx) begin
            r_state <= S_START;
            r_bp    <= bit_period;
            r_cnt   <= '0;
          end
        end
        S_START: begin
          if (r_cnt == w_half) begin
            r_cnt   <= '0;
            r_bit   <= '0;
            r_state <= w_rx ? S_IDLE : S_DATA;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        S_DATA: begin
          if (r_cnt == w_full) begin
            r_cnt   <= '0;
            // LSB arrives first, so shift in from the top.
            r_shift <= {w_rx, r_shift[7:1]};
            r_bit   <= r_bit + 3'd1;
            if (r_bit == 3'd7) r_state <= S_STOP;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        S_STOP: begin
          if (r_cnt == w_full) begin
            r_cnt <= '0;
            if (w_rx) begin
              r_dlv   <= 1'b1;
              r_state <= S_IDLE;
            end else begin
              r_fe    <= 1'b1;
              r_state <= S_BREAK;
            end
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        S_BREAK: begin
          if (w_rx) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // r_shift is untouched for at least half a bit after delivery,
  // so it can be loaded one cycle after the stop sample.
  always_ff @(posedge clk) begin
    if (!nrst) begin
      r_data  <= '0;
      r_valid <= 1'b0;
      r_ov    <= 1'b0;
    end else begin
      r_ov <= 1'b0;
      if (r_dlv) begin
        if (!r_valid || ready) begin
          r_data  <= r_shift;
          r_valid <= 1'b1;
        end else begin
          r_ov <= 1'b1;
        end
      end else if (r_valid && ready) begin
        r_valid <= 1'b0;
      end
    end
  end

  assign data      = r_data;
  assign valid     = r_valid;
  assign frame_err = r_fe;
  assign overrun   = r_ov;
  assign busy      = (r_state != S_IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Directed testbench for uart_rx.
// Drives 8N1 frames and checks delivered bytes and flags.
module tb_uart_rx;

  logic        clk;
  logic        nrst;
  logic [15:0] bit_period;
  logic        serial_in;
  logic [7:0]  data;
  logic        valid;
  logic        ready;
  logic        frame_err;
  logic        overrun;
  logic        busy;

  int n_chk;
  int n_err;
  int fe_n;
  int ov_n;
  int vh_n;
  logic [7:0] q[$];

  uart_rx #(.CNT_W(16), .SYNC_FF(2)) dut (
    .clk        (clk),
    .nrst       (nrst),
    .bit_period (bit_period),
    .serial_in  (serial_in),
    .data       (data),
    .valid      (valid),
    .ready      (ready),
    .frame_err  (frame_err),
    .overrun    (overrun),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (valid && ready) q.push_back(data);
    if (frame_err) fe_n++;
    if (overrun) ov_n++;
    if (valid) vh_n++;
  end

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] b,
                      input int bp,
                      input logic stop);
    serial_in = 1'b0;
    wait_cyc(bp);
    for (int i = 0; i < 8; i++) begin
      serial_in = b[i];
      wait_cyc(bp);
    end
    serial_in = stop;
    wait_cyc(bp);
    serial_in = 1'b1;
  endtask

  task automatic clr();
    fe_n = 0;
    ov_n = 0;
    vh_n = 0;
    q.delete();
  endtask

  function automatic logic [7:0] qat(input int i);
    if (i < q.size()) return q[i];
    return 8'hxx;
  endfunction

  initial begin
    n_chk = 0;
    n_err = 0;
    clr();
    nrst = 1'b0;
    serial_in = 1'b1;
    ready = 1'b1;
    bit_period = 16'd16;
    wait_cyc(3);
    chk("rst_data", data, 8'h00);
    chk("rst_valid", valid, 1'b0);
    chk("rst_fe", frame_err, 1'b0);
    chk("rst_ov", overrun, 1'b0);
    chk("rst_busy", busy, 1'b0);
    nrst = 1'b1;
    wait_cyc(5);

    // 1: single byte, ready high
    clr();
    send(8'hA5, 16, 1'b1);
    wait_cyc(16);
    chk("t1_n", q.size(), 1);
    chk("t1_d", qat(0), 8'hA5);
    chk("t1_vw", vh_n, 1);
    chk("t1_fe", fe_n, 0);
    chk("t1_ov", ov_n, 0);

    // 2: short low glitch is rejected
    clr();
    serial_in = 1'b0;
    wait_cyc(4);
    chk("t2_bsy1", busy, 1'b1);
    wait_cyc(1);
    serial_in = 1'b1;
    wait_cyc(10);
    chk("t2_bsy0", busy, 1'b0);
    wait_cyc(20);
    chk("t2_n", q.size(), 0);
    chk("t2_fe", fe_n, 0);

    // 3: bad stop bit, break, then good byte
    clr();
    send(8'h3C, 16, 1'b0);
    serial_in = 1'b0;
    wait_cyc(40);
    chk("t3_brk", busy, 1'b1);
    serial_in = 1'b1;
    wait_cyc(32);
    chk("t3_idle", busy, 1'b0);
    send(8'h81, 16, 1'b1);
    wait_cyc(16);
    chk("t3_fe", fe_n, 1);
    chk("t3_n", q.size(), 1);
    chk("t3_d", qat(0), 8'h81);

    // 4: overrun with ready low
    clr();
    ready = 1'b0;
    send(8'h11, 16, 1'b1);
    wait_cyc(16);
    chk("t4_v1", valid, 1'b1);
    chk("t4_d1", data, 8'h11);
    chk("t4_ov0", ov_n, 0);
    send(8'h22, 16, 1'b1);
    wait_cyc(16);
    chk("t4_ov1", ov_n, 1);
    chk("t4_d2", data, 8'h11);
    chk("t4_v2", valid, 1'b1);
    ready = 1'b1;
    wait_cyc(1);
    chk("t4_v0", valid, 1'b0);
    chk("t4_n", q.size(), 1);
    chk("t4_q", qat(0), 8'h11);

    // 5: back-to-back frames at a slow rate
    clr();
    bit_period = 16'd705;
    wait_cyc(4);
    send(8'h34, 705, 1'b1);
    send(8'h12, 705, 1'b1);
    send(8'hCD, 705, 1'b1);
    send(8'hAB, 705, 1'b1);
    wait_cyc(705);
    chk("t5_n", q.size(), 4);
    chk("t5_d0", qat(0), 8'h34);
    chk("t5_d1", qat(1), 8'h12);
    chk("t5_d2", qat(2), 8'hCD);
    chk("t5_d3", qat(3), 8'hAB);
    chk("t5_fe", fe_n, 0);
    chk("t5_ov", ov_n, 0);

    // 6: reset mid-frame discards the partial byte
    clr();
    bit_period = 16'd16;
    wait_cyc(4);
    serial_in = 1'b0;
    wait_cyc(16);
    serial_in = 1'b1;
    wait_cyc(16 * 4 + 4);
    nrst = 1'b0;
    wait_cyc(1);
    chk("t6_data", data, 8'h00);
    chk("t6_valid", valid, 1'b0);
    chk("t6_busy", busy, 1'b0);
    chk("t6_fe", frame_err, 1'b0);
    chk("t6_ov", overrun, 1'b0);
    wait_cyc(3);
    nrst = 1'b1;
    wait_cyc(40);
    send(8'h5A, 16, 1'b1);
    wait_cyc(16);
    chk("t6_n", q.size(), 1);
    chk("t6_d", qat(0), 8'h5A);
    chk("t6_fe_n", fe_n, 0);

    $display("Simulation finished: %0d checks, %0d errors",
             n_chk, n_err);
    $finish;
  end

endmodule
